// File: rtl/rc_channel_decoder_pkg.sv
// Shared widths, scaling constants and default pulse limits for the RC channel decoder.
package rc_channel_decoder_pkg;

  localparam int unsigned REC_VAL_BIT_WIDTH = 8;
  localparam int unsigned RC_WIDTH_BITS     = 12;
  localparam int unsigned RC_GAP_BITS       = 15;
  localparam int unsigned RC_SCALE_MULT     = 2089;
  localparam int unsigned RC_SCALE_SHIFT    = 13;
  localparam int unsigned RC_SPAN_US        = 1000;

  localparam int unsigned RC_MIN_PULSE_US   = 1000;
  localparam int unsigned RC_REJECT_LOW_US  = 800;
  localparam int unsigned RC_REJECT_HIGH_US = 2200;
  localparam int unsigned RC_TIMEOUT_US     = 25000;

  // Map a pulse width to 0..255: clamp to the 1000 us span above min_us, then fixed-point scale.
  function automatic logic [REC_VAL_BIT_WIDTH-1:0] rc_scale(
    input logic [RC_WIDTH_BITS-1:0] hi,
    input logic [RC_WIDTH_BITS-1:0] min_us
  );
    logic [RC_WIDTH_BITS-1:0] d;
    logic [22:0]              prod;
    logic [22:0]              shifted;
    if (hi <= min_us) begin
      d = '0;
    end else if ((hi - min_us) >= RC_WIDTH_BITS'(RC_SPAN_US)) begin
      d = RC_WIDTH_BITS'(RC_SPAN_US);
    end else begin
      d = hi - min_us;
    end
    prod    = 23'(d) * 23'(RC_SCALE_MULT);
    shifted = prod >> RC_SCALE_SHIFT;
    return shifted[REC_VAL_BIT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/rc_input_conditioner.sv
// Synchronizes the raw PWM pin, optionally deglitches it, and produces level/rise/fall.
// Optional glitch filter enabled by defining RC_GLITCH_FILTER_EN.
module rc_input_conditioner (
  input  logic clk,
  input  logic resetn,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1_q, sync2_q, prev_q;

  // Synchronizer resets high so a pulse already in progress at reset is never seen as a rise.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef RC_GLITCH_FILTER_EN
  logic [1:0] hold_q;
  logic       filt_q;
  logic       flip;

  // Third consecutive differing sample flips the level in the same cycle (2 cycles of latency).
  always_comb begin
    flip  = (sync2_q != filt_q) && (hold_q == 2'd2);
    level = flip ? sync2_q : filt_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      filt_q <= 1'b1;
      hold_q <= 2'd0;
    end else if (flip) begin
      filt_q <= sync2_q;
      hold_q <= 2'd0;
    end else if (sync2_q != filt_q) begin
      hold_q <= hold_q + 2'd1;
    end else begin
      hold_q <= 2'd0;
    end
  end
`else
  assign level = sync2_q;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= level;
    end
  end

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

endmodule

// File: rtl/rc_channel_decoder.sv
// Measures one RC PWM channel, validates and scales it to 0..255, and flags loss of signal.
// Optional glitch filter in the input conditioner is enabled by defining RC_GLITCH_FILTER_EN.
module rc_channel_decoder
  import rc_channel_decoder_pkg::*;
#(
  parameter int unsigned                  MIN_PULSE_US   = RC_MIN_PULSE_US,
  parameter int unsigned                  REJECT_LOW_US  = RC_REJECT_LOW_US,
  parameter int unsigned                  REJECT_HIGH_US = RC_REJECT_HIGH_US,
  parameter int unsigned                  TIMEOUT_US     = RC_TIMEOUT_US,
  parameter logic [REC_VAL_BIT_WIDTH-1:0] FAILSAFE_VAL   = 8'h00
) (
  input  logic                         us_clk,
  input  logic                         resetn,
  input  logic                         pwm_in,
  output logic [REC_VAL_BIT_WIDTH-1:0] value,
  output logic [RC_WIDTH_BITS-1:0]     width_us,
  output logic                         valid_strobe,
  output logic                         signal_lost
);

  localparam logic [RC_WIDTH_BITS-1:0] MinCnt     = RC_WIDTH_BITS'(MIN_PULSE_US);
  localparam logic [RC_WIDTH_BITS-1:0] LowCnt     = RC_WIDTH_BITS'(REJECT_LOW_US);
  localparam logic [RC_WIDTH_BITS-1:0] HighCnt    = RC_WIDTH_BITS'(REJECT_HIGH_US);
  localparam logic [RC_GAP_BITS-1:0]   TimeoutCnt = RC_GAP_BITS'(TIMEOUT_US);

  typedef enum logic [1:0] {StSyncLow, StWaitRise, StMeasure, StOverlong} state_e;

  state_e                   state_q;
  logic [RC_WIDTH_BITS-1:0] hi_cnt_q;
  logic [RC_GAP_BITS-1:0]   gap_cnt_q, gap_cnt_d;
  logic                     level, rise, fall;

  rc_input_conditioner u_cond (
    .clk    (us_clk),
    .resetn (resetn),
    .pwm_in (pwm_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  always_comb begin
    gap_cnt_d = (gap_cnt_q == TimeoutCnt) ? gap_cnt_q : gap_cnt_q + 1'b1;
  end

  always_ff @(posedge us_clk) begin
    if (!resetn) begin
      state_q      <= StSyncLow;
      hi_cnt_q     <= '0;
      gap_cnt_q    <= '0;
      value        <= FAILSAFE_VAL;
      width_us     <= '0;
      valid_strobe <= 1'b0;
      signal_lost  <= 1'b1;
    end else begin
      valid_strobe <= 1'b0;
      gap_cnt_q    <= gap_cnt_d;
      if (gap_cnt_d == TimeoutCnt) begin
        signal_lost <= 1'b1;
        value       <= FAILSAFE_VAL;
      end
      // The accept path below is written last so it overrides a coincident timeout.
      case (state_q)
        StSyncLow: begin
          if (!level) state_q <= StWaitRise;
        end
        StWaitRise: begin
          if (rise) begin
            // The rise cycle is itself the first high cycle of the pulse.
            hi_cnt_q <= RC_WIDTH_BITS'(1);
            state_q  <= StMeasure;
          end
        end
        StMeasure: begin
          if (fall) begin
            state_q <= StWaitRise;
            if (hi_cnt_q >= LowCnt && hi_cnt_q <= HighCnt) begin
              valid_strobe <= 1'b1;
              width_us     <= hi_cnt_q;
              value        <= rc_scale(hi_cnt_q, MinCnt);
              signal_lost  <= 1'b0;
              gap_cnt_q    <= '0;
            end
          end else if (hi_cnt_q > HighCnt) begin
            state_q <= StOverlong;
          end else begin
            hi_cnt_q <= hi_cnt_q + 1'b1;
          end
        end
        StOverlong: begin
          if (!level) state_q <= StWaitRise;
        end
        default: state_q <= StSyncLow;
      endcase
    end
  end

endmodule
